// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned WORD_IDX_W  = $clog2(BLOCK_WORDS);

  // Byte-offset bits inside one block (word addresses step by 2).
  localparam logic [ADDR_W-1:0] BLOCK_OFFSET_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL_I  = 2'd1,
    FILL_D  = 2'd2,
    WRITE_D = 2'd3
  } state_t;

  // Word address of entry idx inside the block containing base.
  function automatic logic [ADDR_W-1:0] fill_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [WORD_IDX_W-1:0] idx);
    return (base & ~BLOCK_OFFSET_MASK) | ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the memory arbiter.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  d_req;
  logic                  d_wr;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  i_fill_valid;
  logic                  d_fill_valid;
  logic [WORD_IDX_W-1:0] fill_idx;
  logic [DATA_W-1:0]     fill_data;
  logic                  i_done;
  logic                  d_done;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rvalid;
  logic                  busy;

  // Arbiter view.
  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_fill_valid, d_fill_valid, fill_idx, fill_data, i_done, d_done,
           mem_enable, mem_wr, mem_addr, mem_wdata, busy
  );

  // Cache controllers and memory model view.
  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_fill_valid, d_fill_valid, fill_idx, fill_data, i_done, d_done,
           mem_enable, mem_wr, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_block_word_counter.sv
// Word counter within one cache block: clear, enable, terminal flag.
module block_word_counter
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  last_c
);

  // Count words; wraps to zero after the last word of the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WORD_IDX_W'(1);
    end
  end

  assign last_c = (count == WORD_IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: serializes I/D block fills and D single-word writes onto
// one pipelined memory. Optional macro MEM_ARB_RR_EN selects round-robin
// arbitration instead of fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_W-1:0]     base;
  logic [DATA_W-1:0]     wdata;
  logic                  iss_done;
  logic [WORD_IDX_W-1:0] iss;
  logic [WORD_IDX_W-1:0] ret;
  logic                  iss_last;
  logic                  ret_last;
  logic                  grant_i;
  logic                  grant_d;
  logic                  in_fill;
  logic                  idle;
`ifdef MEM_ARB_RR_EN
  logic                  last_grant;  // 1 = D side granted most recently
`endif

  assign idle    = (state == IDLE);
  assign in_fill = (state == FILL_I) || (state == FILL_D);

  block_word_counter u_iss (
    .clk    (clk),
    .rst    (rst),
    .clr    (idle),
    .en     (in_fill && !iss_done),
    .count  (iss),
    .last_c (iss_last)
  );

  block_word_counter u_ret (
    .clk    (clk),
    .rst    (rst),
    .clr    (idle),
    .en     (in_fill && bus.mem_rvalid),
    .count  (ret),
    .last_c (ret_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the granted address/data and track issue completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base     <= '0;
      wdata    <= '0;
      iss_done <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      if (grant_d) begin
        base  <= bus.d_addr;
        wdata <= bus.d_wdata;
      end else if (grant_i) begin
        base <= bus.i_addr;
      end
      if (idle) begin
        iss_done <= 1'b0;
      end else if (in_fill && !iss_done && iss_last) begin
        iss_done <= 1'b1;
      end
`ifdef MEM_ARB_RR_EN
      if (grant_d || grant_i) begin
        last_grant <= grant_d;
      end
`endif
    end
  end

  // Arbitration, next state and memory/cache-side outputs.
  always_comb begin
    state_next       = state;
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    bus.i_fill_valid = 1'b0;
    bus.d_fill_valid = 1'b0;
    bus.fill_idx     = '0;
    bus.fill_data    = '0;
    bus.i_done       = 1'b0;
    bus.d_done       = 1'b0;
    bus.mem_enable   = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.busy         = !idle;
    case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (bus.d_req && bus.i_req) begin
          grant_d = !last_grant;
          grant_i = last_grant;
        end else begin
          grant_d = bus.d_req;
          grant_i = bus.i_req;
        end
`else
        grant_d = bus.d_req;
        grant_i = bus.i_req && !bus.d_req;
`endif
        if (grant_d) begin
          state_next = bus.d_wr ? WRITE_D : FILL_D;
        end else if (grant_i) begin
          state_next = FILL_I;
        end
      end
      FILL_I, FILL_D: begin
        bus.mem_enable = !iss_done;
        if (!iss_done) begin
          bus.mem_addr = fill_addr(base, iss);
        end
        bus.fill_idx     = ret;
        bus.fill_data    = bus.mem_rdata;
        bus.i_fill_valid = (state == FILL_I) && bus.mem_rvalid;
        bus.d_fill_valid = (state == FILL_D) && bus.mem_rvalid;
        if (bus.mem_rvalid && ret_last) begin
          state_next = IDLE;
          bus.i_done = (state == FILL_I);
          bus.d_done = (state == FILL_D);
        end
      end
      WRITE_D: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = base & ~ADDR_W'(1);
        bus.mem_wdata  = wdata;
        bus.d_done     = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model, per-cycle reference model,
// directed table, multi-cycle corner sequences and random traffic.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_LATENCY = 4;
  localparam int M_NONE = 0, M_FI = 1, M_FD = 2, M_WR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        i_fv;
    logic        d_fv;
    logic [2:0]  idx;
    logic [15:0] fdata;
    logic        i_done;
    logic        d_done;
    logic        men;
    logic        mwr;
    logic [15:0] maddr;
    logic [15:0] mwdata;
    logic        busy;
  } obs_t;

  obs_t snap;
  int   snap_cyc;

  // Pipelined memory: a read sampled at edge e returns data=address in the
  // cycle that ends at edge e+MEM_LATENCY. "stray" forces an unsolicited rvalid.
  typedef struct { int due; logic [15:0] addr; } rd_t;
  rd_t  pend[$];
  logic stray = 1'b0;

  initial begin
    logic en, wr;
    logic [15:0] a;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      en = bus.mem_enable; wr = bus.mem_wr; a = bus.mem_addr;
      @(posedge clk);
      if (en && !wr) pend.push_back('{due: cyc + MEM_LATENCY, addr: a});
      #1;
      bus.mem_rvalid = stray;
      bus.mem_rdata  = stray ? 16'hDEAD : 16'h0000;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = pend[0].addr;
        pend.delete(0);
      end
    end
  end

  // Reference model: the current transaction and when it was granted.
  int          m_kind = M_NONE;
  logic [15:0] m_base = '0;
  logic [15:0] m_wdata = '0;
  int          m_t0 = 0;
  logic        m_lg_d = 1'b0;

  function automatic obs_t sample();
    return {bus.i_fill_valid, bus.d_fill_valid, bus.fill_idx, bus.fill_data,
            bus.i_done, bus.d_done, bus.mem_enable, bus.mem_wr,
            bus.mem_addr, bus.mem_wdata, bus.busy};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cyc %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs follow from the grant cycle: words issued on relative
  // cycles 0..7, returned on 4..11, done on 11; a write lasts one cycle.
  task automatic model_check();
    obs_t        e, a;
    int          rel;
    logic [15:0] blk;
    logic        take_d;
    a = sample();
    snap = a;
    snap_cyc = cyc;
    e = '0;
    rel = cyc - m_t0;
    blk = m_base & ~16'h000F;
    if (rst) begin
      m_kind = M_NONE;
      m_lg_d = 1'b0;
    end else if (m_kind == M_WR) begin
      e.men = 1'b1; e.mwr = 1'b1; e.maddr = m_base & ~16'h0001;
      e.mwdata = m_wdata; e.d_done = 1'b1; e.busy = 1'b1;
    end else if (m_kind != M_NONE) begin
      e.busy = 1'b1;
      if (rel < 8) begin
        e.men = 1'b1;
        e.maddr = blk + 16'(2 * rel);
      end
      if (rel >= 4 && rel <= 11) begin
        e.idx   = 3'(rel - 4);
        e.fdata = blk + 16'(2 * (rel - 4));
        if (m_kind == M_FI) e.i_fv = 1'b1; else e.d_fv = 1'b1;
      end
      if (rel == 11) begin
        if (m_kind == M_FI) e.i_done = 1'b1; else e.d_done = 1'b1;
      end
    end
    chk("cycle_outputs", 64'(a), 64'(e));
    if (!rst) begin
      if (m_kind == M_WR || (m_kind != M_NONE && rel == 11)) begin
        m_kind = M_NONE;
      end else if (m_kind == M_NONE && (bus.d_req || bus.i_req)) begin
`ifdef MEM_ARB_RR_EN
        take_d = (bus.d_req && bus.i_req) ? !m_lg_d : bus.d_req;
`else
        take_d = bus.d_req;
`endif
        m_kind  = take_d ? (bus.d_wr ? M_WR : M_FD) : M_FI;
        m_base  = take_d ? bus.d_addr : bus.i_addr;
        m_wdata = bus.d_wdata;
        m_t0    = cyc + 1;
        m_lg_d  = take_d;
      end
    end
  endtask

  // Check the current cycle at the falling edge, return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int who, output int when);
    who = 0; when = -1;
    for (int n = 0; n < budget && who == 0; n++) begin
      tick();
      if (snap.i_done) begin who = 1; when = snap_cyc; end
      else if (snap.d_done) begin who = 2; when = snap_cyc; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t tbl[5];
  int   exp_who[4];

  initial begin
    int who, when, first, start, seen, t_d;
    logic [15:0] got_addr, got_wdata;
    logic got_wr;

    tbl[0] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h1234, wdata: 16'h0000, exp_addr: 16'h1230, exp_lat: 12};
    tbl[1] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h2001, wdata: 16'h0000, exp_addr: 16'h2000, exp_lat: 12};
    tbl[2] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h0101, wdata: 16'hBEEF, exp_addr: 16'h0100, exp_lat: 1};
    tbl[3] = '{is_d: 1'b0, wr: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, exp_addr: 16'hFFF0, exp_lat: 12};
    tbl[4] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h7FFE, wdata: 16'h1234, exp_addr: 16'h7FFE, exp_lat: 1};
`ifdef MEM_ARB_RR_EN
    exp_who = '{2, 1, 2, 1};
`else
    exp_who = '{2, 2, 2, 2};
`endif

    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_state", 64'(snap), 64'(0));

    // Stray rvalids while idle must be ignored.
    #2 stray = 1'b1;
    tick();
    #2 stray = 1'b0;
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (snap.i_fv || snap.d_fv || snap.i_done || snap.d_done || snap.idx != 0) seen++;
    end
    chk("stray_ignored", 64'(seen), 64'(0));

    // Directed single transactions.
    for (int k = 0; k < 5; k++) begin
      start = cyc;
      if (tbl[k].is_d) begin
        bus.d_req = 1'b1; bus.d_wr = tbl[k].wr; bus.d_addr = tbl[k].addr; bus.d_wdata = tbl[k].wdata;
      end else begin
        bus.i_req = 1'b1; bus.i_addr = tbl[k].addr;
      end
      first = -1; got_addr = '0; got_wr = 1'b0; got_wdata = '0; who = 0; when = -1;
      for (int n = 0; n < 30 && who == 0; n++) begin
        tick();
        if (snap.men && first < 0) begin
          first = snap_cyc; got_addr = snap.maddr; got_wr = snap.mwr; got_wdata = snap.mwdata;
        end
        if (snap.i_done) begin who = 1; when = snap_cyc; end
        else if (snap.d_done) begin who = 2; when = snap_cyc; end
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      chk("vec_first_issue_cycle", 64'(first - start), 64'(1));
      chk("vec_first_addr", 64'(got_addr), 64'(tbl[k].exp_addr));
      chk("vec_mem_wr", 64'(got_wr), 64'(tbl[k].wr));
      if (tbl[k].wr) chk("vec_mem_wdata", 64'(got_wdata), 64'(tbl[k].wdata));
      chk("vec_done_side", 64'(who), 64'(tbl[k].is_d ? 2 : 1));
      chk("vec_done_latency", 64'(when - start), 64'(tbl[k].exp_lat));
      tick();
      chk("vec_idle_after", 64'(snap.busy), 64'(0));
    end

    // Simultaneous requests: D fill first, I fill issues two cycles after d_done.
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 16'h1234;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h2000;
    wait_done(30, who, when);
    bus.d_req = 1'b0;
    chk("simul_first_done_side", 64'(who), 64'(2));
    t_d = when;
    first = -1;
    for (int n = 0; n < 10 && first < 0; n++) begin
      tick();
      if (snap.men) begin first = snap_cyc; got_addr = snap.maddr; end
    end
    chk("simul_i_start_gap", 64'(first - t_d), 64'(2));
    chk("simul_i_first_addr", 64'(got_addr), 64'(16'h1230));
    wait_done(30, who, when);
    bus.i_req = 1'b0;
    chk("simul_second_done_side", 64'(who), 64'(1));
    tick();

    // Asynchronous reset in the middle of an I fill (grant edge T, reset at T+5).
    bus.i_req = 1'b1; bus.i_addr = 16'h1234;
    for (int n = 0; n < 6; n++) tick();
    rst = 1'b1; bus.i_req = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(sample()), 64'(0));
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (snap.i_fv || snap.d_fv || snap.i_done || snap.d_done) seen++;
    end
    chk("reset_drain_ignored", 64'(seen), 64'(0));
    chk("reset_pending_drained", 64'(pend.size()), 64'(0));
    bus.i_req = 1'b1; bus.i_addr = 16'h0050;
    first = -1;
    for (int n = 0; n < 20 && first < 0; n++) begin
      tick();
      if (snap.i_fv) begin first = snap_cyc; got_addr = snap.fdata; got_wdata = 16'(snap.idx); end
    end
    chk("restart_first_idx", 64'(got_wdata), 64'(0));
    chk("restart_first_data", 64'(got_addr), 64'(16'h0050));
    wait_done(30, who, when);
    bus.i_req = 1'b0;
    chk("restart_done_side", 64'(who), 64'(1));
    tick();

    // Both requests held for four transactions.
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 16'h3000;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h4000;
    for (int t = 0; t < 4; t++) begin
      wait_done(30, who, when);
      if (t == 3) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      chk($sformatf("held_grant_%0d", t), 64'(who), 64'(exp_who[t]));
    end
    tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      if (bus.i_req) begin
        if (snap.i_done) bus.i_req = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.i_req = 1'b1; bus.i_addr = 16'($urandom);
      end
      if (bus.d_req) begin
        if (snap.d_done) bus.d_req = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        bus.d_req = 1'b1; bus.d_wr = ($urandom_range(2) == 0);
        bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one multi-cycle main memory between the I-cache miss path and the D-cache miss/write-through path of the pipelined CPU. It serializes block fills (8 words) and single-word writes, and issues word addresses back-to-back to a pipelined memory. It returns fill data to the requester that owns the transaction and pulses a done signal so the pipeline stall can be released. It sits between the cache controllers and the memory model.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, word width
MEM_LATENCY, 4, cycles from mem_enable issue to matching mem_rvalid (used only by the bench and assertions; the arbiter counts returns and does not time them)
BLOCK_WORDS, 8, words per cache block (power of 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_req  in  1  I-side block fill request, held until i_done
i_addr  in  ADDR_W  I-side miss address
d_req  in  1  D-side request, held until d_done
d_wr  in  1  1 = single-word write, 0 = block fill
d_addr  in  ADDR_W  D-side address
d_wdata  in  DATA_W  D-side write data
i_fill_valid  out  1  fill_data belongs to the I side
d_fill_valid  out  1  fill_data belongs to the D side
fill_idx  out  3  word index of the returned word within the block
fill_data  out  DATA_W  returned word, passed through from mem_rdata
i_done  out  1  one-cycle pulse, I transaction complete
d_done  out  1  one-cycle pulse, D transaction complete
mem_enable  out  1  memory access strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  word address issued to memory
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  mem_rdata valid
busy  out  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, FILL_I, FILL_D, WRITE_D. Reset (async) forces IDLE, clears both counters and the latched address. All outputs are 0 during and after reset until a grant.
- IDLE arbitration (registered), default priority is D over I:
  - d_req with d_wr=1 -> WRITE_D
  - d_req with d_wr=0 -> FILL_D
  - else i_req -> FILL_I
  - The granted address is latched in the grant cycle; later changes to the address inputs are ignored.
- FILL_x:
  - Issue counter iss counts 0..BLOCK_WORDS-1.
  - While iss < BLOCK_WORDS: mem_enable=1, mem_wr=0, mem_addr={base[15:4], iss, 1'b0}, and iss increments every cycle.
  - After 8 issues, mem_enable=0.
  - Return counter ret increments on each mem_rvalid.
  - fill_idx=ret, fill_data=mem_rdata, and the owning x_fill_valid=mem_rvalid, all combinational.
  - x_done is asserted in the same cycle as the 8th mem_rvalid; the next state is IDLE.
- FILL timing: grant sampled at edge T, words issued T+1..T+8, done at T+8+MEM_LATENCY (T+12 by default), IDLE at T+13.
- WRITE_D: for one cycle, mem_enable=1, mem_wr=1, mem_addr=d_addr with bit0 cleared, mem_wdata=d_wdata, d_done=1. Next state is IDLE.
- Requesters drop req on the clock edge at which done is sampled. A req seen high in IDLE is always treated as a new request, so back-to-back transactions have a 1-cycle IDLE gap.
- Dropping req mid-transaction is ignored; a transaction always completes.
- mem_rvalid arriving in IDLE or WRITE_D is ignored: no fill_valid, counters unchanged.
- Address LSB is ignored and fill base alignment is forced, so misaligned addresses are legal.
- i_fill_valid and d_fill_valid are never high together. i_done and d_done are never high together.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last_grant register, reset to I, records the most recent grant (writes count as D). When both requests are pending in IDLE, the side not granted last wins.
- Undefined: fixed D-over-I priority; last_grant is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, FILL_I, FILL_D, WRITE_D)
  - BLOCK_WORDS and its log2 (WORD_IDX_W = 3)
  - the block offset mask constant
- One natural sub-module, block_word_counter: a 3-bit counter with clear, enable, and terminal flag, instantiated twice (iss, ret).

Test Plan:
- I fill, i_addr=0x1234, memory returns data=addr -> mem_addr 0x1230,0x1232,…,0x123E on T+1..T+8; i_fill_valid with idx 0..7 and data 0x1230..0x123E; i_done at T+12; busy low at T+13.
- i_req and d_req(d_wr=0, d_addr=0x2000) raised in the same cycle -> D fill on 0x2000..0x200E first; I fill begins 2 cycles after d_done; never both fill_valids high.
- D write, d_addr=0x0101, d_wdata=0xBEEF -> one cycle with mem_enable=mem_wr=1, mem_addr=0x0100, mem_wdata=0xBEEF, d_done=1; IDLE next cycle.
- rst asserted at T+5 of an I fill -> all outputs 0 immediately; pending mem_rvalids produce no i_fill_valid and no i_done; a new i_req after reset restarts at idx 0.
- Stray mem_rvalid while in IDLE -> no fill_valid, no done, counters remain 0.
- Both requests held continuously for 4 transactions:
  - MEM_ARB_RR_EN defined -> grants D,I,D,I.
  - Undefined -> grants D,D,D,D with I starved.
